instr_sequencer: RTL

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// Instruction sequencer: issues a small program buffer to a CPU one word at
// a time, handshaking on the CPU wait flag with a per-instruction watchdog.
module instr_sequencer #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic [3:0]  prog_len,
    input  logic        go,
    input  logic        cpu_w,
    output logic [15:0] cpu_in,
    output logic        cpu_load,
    output logic        cpu_s,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [2:0]  pc,
    output logic [3:0]  issued
);

    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WW-1:0] WD_LIM = WW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, START, WBUSY, WDONE, FIN
    } state_t;

    state_t         state, state_nx;
    logic [15:0]    mem [8];
    logic [3:0]     len, len_nx;
    logic [2:0]     pc_nx;
    logic [3:0]     issued_nx;
    logic [WW-1:0]  wdog, wdog_nx;
    logic           timeout_nx;
    logic [15:0]    cpu_in_nx;
    logic           wd_hit;
    logic           last;

    assign wd_hit = (wdog == WD_LIM);
    assign last   = ({1'b0, pc} == len - 4'd1);

    always_comb begin
        state_nx   = state;
        len_nx     = len;
        pc_nx      = pc;
        issued_nx  = issued;
        wdog_nx    = wdog;
        timeout_nx = timeout;
        unique case (state)
            IDLE: begin
                if (go && prog_len == 4'd0) begin
                    state_nx   = FIN;
                    pc_nx      = 3'd0;
                    issued_nx  = 4'd0;
                    timeout_nx = 1'b0;
                end else if (go && cpu_w) begin
                    state_nx   = LOAD;
                    len_nx     = (prog_len > 4'd8) ? 4'd8 : prog_len;
                    pc_nx      = 3'd0;
                    issued_nx  = 4'd0;
                    timeout_nx = 1'b0;
                end
            end
            LOAD: begin
                state_nx = START;
                wdog_nx  = '0;
            end
            START: state_nx = WBUSY;
            WBUSY: begin
                if (wd_hit) begin
                    state_nx   = IDLE;
                    timeout_nx = 1'b1;
                end else begin
                    wdog_nx = wdog + 1'b1;
                    if (!cpu_w) state_nx = WDONE;
                end
            end
            WDONE: begin
                if (wd_hit) begin
                    state_nx   = IDLE;
                    timeout_nx = 1'b1;
                end else begin
                    wdog_nx = wdog + 1'b1;
                    if (cpu_w) begin
                        issued_nx = (issued == 4'd8) ? issued : issued + 4'd1;
                        if (last) begin
                            state_nx = FIN;
                        end else begin
                            pc_nx    = pc + 3'd1;
                            state_nx = LOAD;
                        end
                    end
                end
            end
            FIN: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The word for the next LOAD is fetched here so cpu_in is a flop output.
    always_comb begin
        cpu_in_nx = cpu_in;
        if (state_nx == LOAD) cpu_in_nx = mem[pc_nx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            len      <= 4'd0;
            pc       <= 3'd0;
            issued   <= 4'd0;
            wdog     <= '0;
            timeout  <= 1'b0;
            cpu_in   <= 16'd0;
            cpu_load <= 1'b0;
            cpu_s    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            len      <= len_nx;
            pc       <= pc_nx;
            issued   <= issued_nx;
            wdog     <= wdog_nx;
            timeout  <= timeout_nx;
            cpu_in   <= cpu_in_nx;
            cpu_load <= (state_nx == LOAD);
            cpu_s    <= (state_nx == START);
            busy     <= (state_nx != IDLE);
            done     <= (state_nx == FIN);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) mem[i] <= 16'd0;
        end else if (wr_en && !busy) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule
